// File: rtl/conv_addr_gen.sv
// Sliding-window address generator: snapshots a convolution config on start and
// streams one image/weight read-address pair per kernel tap over valid/ready.
module conv_addr_gen #(
    parameter int IMG_AW = 10,
    parameter int WGT_AW = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        kernel_size,
    input  logic [4:0]        img_size,
    input  logic [1:0]        stride,
    input  logic [4:0]        width_size,
    input  logic [4:0]        number_kernel,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IMG_AW-1:0] img_addr,
    output logic [WGT_AW-1:0] wgt_addr,
    output logic              win_first,
    output logic              win_last,
    output logic [4:0]        kern_idx,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_RUN, S_FIN} state_t;

    state_t state, state_nxt;

    logic [2:0] k_q;
    logic [4:0] n_q, p_q, m_q, o_q;
    logic [1:0] s_q;

    logic [4:0] m_cnt, orow, ocol;
    logic [2:0] kr, kc;

    logic [4:0] m_n, orow_n, ocol_n;
    logic [2:0] kr_n, kc_n;

    logic cfg_bad, fire, last_beat;
    logic kc_wrap, kr_wrap, ocol_wrap, orow_wrap, m_wrap;
    logic [4:0] diff, o_calc;
    logic [1:0] s_div;
    logic [IMG_AW-1:0] img_calc;
    logic [WGT_AW-1:0] wgt_calc;

    // Config legality and output-grid size, evaluated from the snapshot in CHECK.
    always_comb begin
        cfg_bad = (k_q == 3'd0) || (s_q == 2'd0) || (m_q == 5'd0) ||
                  ({2'b00, k_q} > n_q) || (p_q < n_q);
        s_div   = (s_q == 2'd0) ? 2'd1 : s_q;
        diff    = n_q - {2'b00, k_q};
        o_calc  = diff / {3'b000, s_div} + 5'd1;
    end

    always_comb begin
        fire      = out_valid && out_ready;
        kc_wrap   = (kc == k_q - 3'd1);
        kr_wrap   = (kr == k_q - 3'd1);
        ocol_wrap = (ocol == o_q - 5'd1);
        orow_wrap = (orow == o_q - 5'd1);
        m_wrap    = (m_cnt == m_q - 5'd1);
        last_beat = kc_wrap && kr_wrap && ocol_wrap && orow_wrap && m_wrap;

        kc_n   = kc_wrap ? 3'd0 : kc + 3'd1;
        kr_n   = kr;
        ocol_n = ocol;
        orow_n = orow;
        m_n    = m_cnt;
        if (kc_wrap) begin
            kr_n = kr_wrap ? 3'd0 : kr + 3'd1;
            if (kr_wrap) begin
                ocol_n = ocol_wrap ? 5'd0 : ocol + 5'd1;
                if (ocol_wrap) begin
                    orow_n = orow_wrap ? 5'd0 : orow + 5'd1;
                    if (orow_wrap) begin
                        m_n = m_cnt + 5'd1;
                    end
                end
            end
        end

        // Modular arithmetic at the port width equals truncating the full-precision result.
        img_calc = (IMG_AW'(orow_n) * IMG_AW'(s_q) + IMG_AW'(kr_n)) * IMG_AW'(p_q)
                 + IMG_AW'(ocol_n) * IMG_AW'(s_q) + IMG_AW'(kc_n);
        wgt_calc = WGT_AW'(m_n) * WGT_AW'(k_q) * WGT_AW'(k_q)
                 + WGT_AW'(kr_n) * WGT_AW'(k_q) + WGT_AW'(kc_n);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_CHECK;
            S_CHECK: state_nxt = cfg_bad ? S_FIN : S_RUN;
            S_RUN:   if (fire && last_beat) state_nxt = S_FIN;
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k_q       <= '0;
            n_q       <= '0;
            s_q       <= '0;
            p_q       <= '0;
            m_q       <= '0;
            o_q       <= '0;
            m_cnt     <= '0;
            orow      <= '0;
            ocol      <= '0;
            kr        <= '0;
            kc        <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            img_addr  <= '0;
            wgt_addr  <= '0;
            win_first <= 1'b0;
            win_last  <= 1'b0;
            kern_idx  <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        k_q  <= kernel_size;
                        n_q  <= img_size;
                        s_q  <= stride;
                        p_q  <= width_size;
                        m_q  <= number_kernel;
                        err  <= 1'b0;
                        busy <= 1'b1;
                    end
                end
                S_CHECK: begin
                    if (cfg_bad) begin
                        err  <= 1'b1;
                        done <= 1'b1;
                    end else begin
                        o_q       <= o_calc;
                        m_cnt     <= '0;
                        orow      <= '0;
                        ocol      <= '0;
                        kr        <= '0;
                        kc        <= '0;
                        out_valid <= 1'b1;
                        img_addr  <= '0;
                        wgt_addr  <= '0;
                        win_first <= 1'b1;
                        win_last  <= (k_q == 3'd1);
                        kern_idx  <= '0;
                    end
                end
                S_RUN: begin
                    if (fire) begin
                        if (last_beat) begin
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            m_cnt     <= m_n;
                            orow      <= orow_n;
                            ocol      <= ocol_n;
                            kr        <= kr_n;
                            kc        <= kc_n;
                            img_addr  <= img_calc;
                            wgt_addr  <= wgt_calc;
                            win_first <= (kr_n == 3'd0) && (kc_n == 3'd0);
                            win_last  <= (kr_n == k_q - 3'd1) && (kc_n == k_q - 3'd1);
                            kern_idx  <= m_n;
                        end
                    end
                end
                S_FIN: begin
                    busy <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_addr_gen.sv
// Self-checking bench for conv_addr_gen: a loop-nest model of the tap order feeds a
// scoreboard queue that one negedge compare process checks every accepted beat against.
module tb_conv_addr_gen;

    localparam int IMG_AW = 10;
    localparam int WGT_AW = 11;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [2:0]        kernel_size;
    logic [4:0]        img_size;
    logic [1:0]        stride;
    logic [4:0]        width_size;
    logic [4:0]        number_kernel;
    logic              busy;
    logic              out_valid;
    logic              out_ready;
    logic [IMG_AW-1:0] img_addr;
    logic [WGT_AW-1:0] wgt_addr;
    logic              win_first;
    logic              win_last;
    logic [4:0]        kern_idx;
    logic              done;
    logic              err;

    always #5 clk = ~clk;

    conv_addr_gen #(.IMG_AW(IMG_AW), .WGT_AW(WGT_AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .kernel_size(kernel_size), .img_size(img_size), .stride(stride),
        .width_size(width_size), .number_kernel(number_kernel),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .img_addr(img_addr), .wgt_addr(wgt_addr),
        .win_first(win_first), .win_last(win_last), .kern_idx(kern_idx),
        .done(done), .err(err)
    );

    typedef struct {
        int img;
        int wgt;
        int first;
        int last;
        int kern;
    } beat_t;

    beat_t exp_q[$];
    beat_t cur;
    int    checks   = 0;
    int    errors   = 0;
    int    beat_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected beat sequence straight from the loop-nest definition of the walk.
    function automatic void build_model(input int k, input int n, input int s, input int p, input int m);
        int o;
        beat_t b;
        o = (n - k) / s + 1;
        exp_q.delete();
        for (int mm = 0; mm < m; mm++)
            for (int r = 0; r < o; r++)
                for (int c = 0; c < o; c++)
                    for (int a = 0; a < k; a++)
                        for (int d = 0; d < k; d++) begin
                            b.img   = ((r * s + a) * p + c * s + d) % (1 << IMG_AW);
                            b.wgt   = (mm * k * k + a * k + d) % (1 << WGT_AW);
                            b.first = (a == 0 && d == 0) ? 1 : 0;
                            b.last  = (a == k - 1 && d == k - 1) ? 1 : 0;
                            b.kern  = mm;
                            exp_q.push_back(b);
                        end
    endfunction

    logic              prev_valid = 1'b0;
    logic              prev_ready = 1'b0;
    logic [IMG_AW-1:0] prev_img;
    logic [WGT_AW-1:0] prev_wgt;
    logic              prev_first, prev_last;
    logic [4:0]        prev_kern;

    // Scoreboard: every accepted beat is checked; stalled beats must hold still.
    always @(negedge clk) begin
        if (out_valid) begin
            if (prev_valid && !prev_ready) begin
                check("stall_img", img_addr, prev_img);
                check("stall_wgt", wgt_addr, prev_wgt);
                check("stall_first", win_first, prev_first);
                check("stall_last", win_last, prev_last);
                check("stall_kern", kern_idx, prev_kern);
            end
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", out_valid, 0);
                end else begin
                    cur = exp_q.pop_front();
                    check("img_addr", img_addr, cur.img);
                    check("wgt_addr", wgt_addr, cur.wgt);
                    check("win_first", win_first, cur.first);
                    check("win_last", win_last, cur.last);
                    check("kern_idx", kern_idx, cur.kern);
                    beat_cnt++;
                end
            end
        end else if (prev_valid && !prev_ready) begin
            check("valid_drop_in_stall", out_valid, 1);
        end
        prev_valid <= out_valid;
        prev_ready <= out_ready;
        prev_img   <= img_addr;
        prev_wgt   <= wgt_addr;
        prev_first <= win_first;
        prev_last  <= win_last;
        prev_kern  <= kern_idx;
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_img"}, img_addr, 0);
        check({tag, "_wgt"}, wgt_addr, 0);
        check({tag, "_first"}, win_first, 0);
        check({tag, "_last"}, win_last, 0);
        check({tag, "_kern"}, kern_idx, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
    endtask

    // Start a run against the current model queue; rst_at >= 0 aborts via reset after that many beats.
    task automatic do_run(input int k, input int n, input int s, input int p, input int m,
                          input bit bp, input int rst_at);
        int cyc;
        int total;
        int budget;
        total    = exp_q.size();
        budget   = total * 4 + 50;
        beat_cnt = 0;
        @(posedge clk); #1;
        kernel_size   = 3'(k);
        img_size      = 5'(n);
        stride        = 2'(s);
        width_size    = 5'(p);
        number_kernel = 5'(m);
        start         = 1'b1;
        out_ready     = 1'b1;
        @(negedge clk);
        check("idle_before_start_busy", busy, 0);
        @(posedge clk); #1;
        start         = 1'b0;
        kernel_size   = 3'd0;
        img_size      = 5'd0;
        stride        = 2'd0;
        width_size    = 5'd0;
        number_kernel = 5'd0;
        @(negedge clk);
        check("check_busy", busy, 1);
        check("check_no_valid", out_valid, 0);
        check("check_err_cleared", err, 0);
        cyc = 0;
        while (!done && cyc < budget) begin
            if (rst_at >= 0 && beat_cnt >= rst_at) begin
                rst_n = 1'b0;
                @(posedge clk); #1;
                @(negedge clk);
                check_all_zero("midrun_reset");
                @(posedge clk); #1;
                rst_n = 1'b1;
                repeat (4) begin
                    @(negedge clk);
                    check("post_reset_no_done", done, 0);
                    check("post_reset_no_valid", out_valid, 0);
                    check("post_reset_idle", busy, 0);
                end
                exp_q.delete();
                return;
            end
            @(posedge clk); #1;
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            start     = (cyc == 5);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("done_seen", done, 1);
        check("done_no_valid", out_valid, 0);
        check("done_busy", busy, 1);
        check("done_no_err", err, 0);
        check("beat_count", beat_cnt, total);
        check("model_drained", exp_q.size(), 0);
    endtask

    task automatic do_err_run();
        @(posedge clk); #1;
        kernel_size   = 3'd6;
        img_size      = 5'd5;
        stride        = 2'd1;
        width_size    = 5'd5;
        number_kernel = 5'd1;
        start         = 1'b1;
        out_ready     = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("err_idle_busy", busy, 0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("err_check_busy", busy, 1);
        check("err_check_done", done, 0);
        check("err_check_valid", out_valid, 0);
        @(negedge clk);
        check("err_fin_done", done, 1);
        check("err_fin_err", err, 1);
        check("err_fin_valid", out_valid, 0);
        check("err_fin_busy", busy, 1);
        @(negedge clk);
        check("err_idle_done", done, 0);
        check("err_hold", err, 1);
        check("err_idle_busy2", busy, 0);
        check("err_idle_valid", out_valid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got %0d, expected %0d", 0, 1);
        $fatal(1, "simulation did not finish");
    end

    initial begin
        rst_n         = 1'b0;
        start         = 1'b0;
        kernel_size   = 3'd0;
        img_size      = 5'd0;
        stride        = 2'd0;
        width_size    = 5'd0;
        number_kernel = 5'd0;
        out_ready     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // N=5 K=3 S=1 P=5 M=1: O=3, 81 beats.
        build_model(3, 5, 1, 5, 1);
        begin
            int t1_img[9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
            for (int i = 0; i < 9; i++) check("t1_model_img", exp_q[i].img, t1_img[i]);
        end
        check("t1_model_size", exp_q.size(), 81);
        check("t1_model_first0", exp_q[0].first, 1);
        check("t1_model_last8", exp_q[8].last, 1);
        check("t1_model_last_img", exp_q[80].img, 24);
        check("t1_model_last_wgt", exp_q[80].wgt, 8);
        do_run(3, 5, 1, 5, 1, 1'b0, -1);

        // N=5 K=3 S=2 P=8 M=1: O=2, 36 beats (back-to-back start after done).
        build_model(3, 5, 2, 8, 1);
        check("t2_model_size", exp_q.size(), 36);
        check("t2_model_win01", exp_q[9].img, 2);
        check("t2_model_win10", exp_q[18].img, 16);
        check("t2_model_last_img", exp_q[35].img, 36);
        do_run(3, 5, 2, 8, 1, 1'b0, -1);

        // N=4 K=2 S=1 P=4 M=2: 72 beats, kernel switch at beat 36.
        build_model(2, 4, 1, 4, 2);
        check("t3_model_size", exp_q.size(), 72);
        check("t3_model_kern35", exp_q[35].kern, 0);
        check("t3_model_kern36", exp_q[36].kern, 1);
        check("t3_model_wgt36", exp_q[36].wgt, 4);
        check("t3_model_img36", exp_q[36].img, 0);
        do_run(2, 4, 1, 4, 2, 1'b0, -1);

        // Test 1 again under random backpressure.
        build_model(3, 5, 1, 5, 1);
        do_run(3, 5, 1, 5, 1, 1'b1, -1);

        // K=1: every beat is both first and last of its window.
        build_model(1, 3, 1, 3, 2);
        check("k1_model_size", exp_q.size(), 18);
        check("k1_model_first", exp_q[5].first, 1);
        check("k1_model_last", exp_q[5].last, 1);
        do_run(1, 3, 1, 3, 2, 1'b0, -1);

        // Illegal K>N, then a legal start must clear err.
        do_err_run();
        build_model(3, 5, 2, 8, 1);
        do_run(3, 5, 2, 8, 1, 1'b0, -1);

        // Reset at beat 40 of test 1, then a clean full rerun.
        build_model(3, 5, 1, 5, 1);
        do_run(3, 5, 1, 5, 1, 1'b0, 40);
        build_model(3, 5, 1, 5, 1);
        do_run(3, 5, 1, 5, 1, 1'b0, -1);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
